// File: rtl/uart_rx_frame_timer.sv
// RX frame timer: edge/bit counters, frame phase tracking, triple-sample strobe, frame-done pulse.
// Optional macro RX_EARLY_STOP_EN ends the frame right after the final stop bit's third sample.
module uart_rx_frame_timer #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_MAX   = 8,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  start_det,
  input  logic                  abort,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  parity_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic [2:0]            phase,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_e;

  phase_e                r_phase, w_phase_nxt;
  logic [PRESCALE_W-1:0] r_edge_cnt, w_edge_cnt_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [PRESCALE_W-1:0] r_prescale_l, w_prescale_l_nxt;
  logic [3:0]            r_data_len_l, w_data_len_l_nxt;
  logic                  r_parity_en_l, w_parity_en_l_nxt;
  logic                  r_stop2_l, w_stop2_l_nxt;
  logic                  r_stop_second, w_stop_second_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;

  logic                  w_cfg_ok;
  logic                  w_busy;
  logic                  w_bit_done;
  logic                  w_sample_stb;
  logic [1:0]            w_sample_idx;
  logic [PRESCALE_W-1:0] w_pm1;
  logic [PRESCALE_W-1:0] w_mid;
  logic [BIT_CNT_W-1:0]  w_last_bit;
  logic                  w_final_stop;

  assign w_cfg_ok     = (prescale >= PRESCALE_W'(4)) && (data_len >= 4'd5) &&
                        (int'(data_len) <= DATA_MAX);
  assign w_pm1        = r_prescale_l - PRESCALE_W'(1);
  assign w_mid        = r_prescale_l >> 1;
  assign w_last_bit   = BIT_CNT_W'(r_data_len_l) - BIT_CNT_W'(1);
  assign w_final_stop = !r_stop2_l || r_stop_second;

  // State register; abort wins over everything and ignores enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           r_phase <= PH_IDLE;
    else if (abort)     r_phase <= PH_IDLE;
    else if (enable)    r_phase <= w_phase_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_prescale_l  <= '0;
      r_data_len_l  <= '0;
      r_parity_en_l <= 1'b0;
      r_stop2_l     <= 1'b0;
      r_stop_second <= 1'b0;
      r_frame_done  <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else if (abort) begin
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_stop_second <= 1'b0;
      r_frame_done  <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else if (enable) begin
      r_edge_cnt    <= w_edge_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_prescale_l  <= w_prescale_l_nxt;
      r_data_len_l  <= w_data_len_l_nxt;
      r_parity_en_l <= w_parity_en_l_nxt;
      r_stop2_l     <= w_stop2_l_nxt;
      r_stop_second <= w_stop_second_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_cfg_err     <= w_cfg_err_nxt;
    end
  end

  // Next-state and datapath next values, assuming an enabled, non-aborted cycle.
  always_comb begin
    w_phase_nxt       = r_phase;
    w_edge_cnt_nxt    = r_edge_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_prescale_l_nxt  = r_prescale_l;
    w_data_len_l_nxt  = r_data_len_l;
    w_parity_en_l_nxt = r_parity_en_l;
    w_stop2_l_nxt     = r_stop2_l;
    w_stop_second_nxt = r_stop_second;
    w_frame_done_nxt  = 1'b0;
    w_cfg_err_nxt     = 1'b0;
    if (r_phase == PH_IDLE) begin
      if (start_det) begin
        if (w_cfg_ok) begin
          w_phase_nxt       = PH_START;
          w_edge_cnt_nxt    = '0;
          w_bit_cnt_nxt     = '0;
          w_stop_second_nxt = 1'b0;
          w_prescale_l_nxt  = prescale;
          w_data_len_l_nxt  = data_len;
          w_parity_en_l_nxt = parity_en;
          w_stop2_l_nxt     = stop2;
        end else begin
          w_cfg_err_nxt = 1'b1;
        end
      end
    end else begin
      w_edge_cnt_nxt = w_bit_done ? '0 : r_edge_cnt + PRESCALE_W'(1);
      case (r_phase)
        PH_START: if (w_bit_done) begin
          w_phase_nxt   = PH_DATA;
          w_bit_cnt_nxt = '0;
        end
        PH_DATA: if (w_bit_done) begin
          if (r_bit_cnt == w_last_bit) begin
            w_bit_cnt_nxt = '0;
            w_phase_nxt   = r_parity_en_l ? PH_PARITY : PH_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
        PH_PARITY: if (w_bit_done) w_phase_nxt = PH_STOP;
        PH_STOP: begin
`ifdef RX_EARLY_STOP_EN
          if (w_final_stop && w_sample_stb && (w_sample_idx == 2'd2)) begin
            w_phase_nxt       = PH_IDLE;
            w_edge_cnt_nxt    = '0;
            w_frame_done_nxt  = 1'b1;
            w_stop_second_nxt = 1'b0;
          end else if (w_bit_done) begin
            w_stop_second_nxt = 1'b1;
          end
`else
          if (w_bit_done) begin
            if (w_final_stop) begin
              w_phase_nxt       = PH_IDLE;
              w_frame_done_nxt  = 1'b1;
              w_stop_second_nxt = 1'b0;
            end else begin
              w_stop_second_nxt = 1'b1;
            end
          end
`endif
        end
        default: w_phase_nxt = PH_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    w_busy       = (r_phase != PH_IDLE);
    w_bit_done   = w_busy && (r_edge_cnt == w_pm1);
    w_sample_stb = 1'b0;
    w_sample_idx = 2'd0;
    if (w_busy) begin
      if (r_edge_cnt == w_mid - PRESCALE_W'(1)) begin
        w_sample_stb = 1'b1;
        w_sample_idx = 2'd0;
      end else if (r_edge_cnt == w_mid) begin
        w_sample_stb = 1'b1;
        w_sample_idx = 2'd1;
      end else if (r_edge_cnt == w_mid + PRESCALE_W'(1)) begin
        w_sample_stb = 1'b1;
        w_sample_idx = 2'd2;
      end
    end
  end

  assign edge_cnt   = r_edge_cnt;
  assign bit_cnt    = r_bit_cnt;
  assign bit_done   = w_bit_done;
  assign sample_stb = w_sample_stb;
  assign sample_idx = w_sample_idx;
  assign phase      = r_phase;
  assign frame_done = r_frame_done;
  assign busy       = w_busy;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed bench for uart_rx_frame_timer (default build): frame timing, sampling, config errors, abort, freeze, reset.
module tb_uart_rx_frame_timer;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0, RST = 1'b0, enable = 1'b0, start_det = 1'b0, abort = 1'b0;
  logic          parity_en = 1'b0, stop2 = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [3:0]    data_len = '0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_done, sample_stb, frame_done, busy, cfg_err;
  logic [1:0]    sample_idx;
  logic [2:0]    phase;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_timer #(.PRESCALE_W(PW), .DATA_MAX(8), .BIT_CNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .start_det(start_det), .abort(abort),
    .prescale(prescale), .data_len(data_len), .parity_en(parity_en), .stop2(stop2),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_done(bit_done), .sample_stb(sample_stb),
    .sample_idx(sample_idx), .phase(phase), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0 || edge_cnt !== '0 || bit_cnt !== '0 || frame_done !== 1'b0 ||
        sample_stb !== 1'b0 || bit_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got ph=%0d busy=%b e=%0d b=%0d fd=%b stb=%b bd=%b want all 0",
               nm, phase, busy, edge_cnt, bit_cnt, frame_done, sample_stb, bit_done);
    end
  endtask

  // Accept a frame; the config inputs are scrambled afterwards to prove they were latched.
  task automatic start_frame(input int p, input int d, input bit par, input bit s2);
    prescale = PW'(p); data_len = 4'(d); parity_en = par; stop2 = s2; start_det = 1'b1;
    tick;
    start_det = 1'b0; prescale = PW'(5); data_len = 4'd6; parity_en = ~par; stop2 = ~s2;
  endtask

  // Walk a frame from START entry, checking every cycle against a timing model.
  task automatic run_frame(input int p, input int d, input bit par, input bit s2,
                           input int hold_at, input int hold_len, input string nm);
    int t, n, c, e, b, ep, eb, ei, mid;
    bit es, ebd, en, done;
    t = 1 + d + int'(par) + 1 + int'(s2);
    n = 0; c = 0; done = 0; mid = p / 2;
    while (!done && c < t * p + hold_len + 5) begin
      if (n == t * p) begin
        checks++;
        if (frame_done !== 1'b1 || phase !== 3'd0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s end c=%0d got fd=%b ph=%0d busy=%b want fd=1 ph=0 busy=0",
                   nm, c, frame_done, phase, busy);
        end
        done = 1;
      end else begin
        e = n % p; b = n / p;
        ep = (b == 0) ? 1 : (b <= d) ? 2 : (par && b == d + 1) ? 3 : 4;
        eb = (b >= 1 && b <= d) ? b - 1 : 0;
        es = (e >= mid - 1) && (e <= mid + 1);
        ei = es ? e - (mid - 1) : 0;
        ebd = (e == p - 1);
        checks++;
        if (phase !== 3'(ep) || edge_cnt !== PW'(e) || bit_cnt !== BW'(eb) || sample_stb !== es ||
            sample_idx !== 2'(ei) || bit_done !== ebd || frame_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s c=%0d got ph=%0d e=%0d b=%0d stb=%b idx=%0d bd=%b fd=%b want ph=%0d e=%0d b=%0d stb=%b idx=%0d bd=%b fd=0",
                   nm, c, phase, edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done,
                   ep, e, eb, es, ei, ebd);
        end
        en = !(c >= hold_at && c < hold_at + hold_len);
        enable = en;
        tick;
        c++;
        if (en) n++;
      end
    end
    enable = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout got no frame end want frame_done at %0d", nm, t * p + hold_len);
    end
    tick;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post got fd=%b busy=%b want 0 0", nm, frame_done, busy);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; #2;
    check_idle("reset_state");
    checks++;
    if (cfg_err !== 1'b0 || sample_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_misc got cfg_err=%b idx=%0d want 0 0", cfg_err, sample_idx);
    end
    tick; RST = 1'b1; enable = 1'b1; tick;
    check_idle("reset_release");
  endtask

  task automatic test_basic_8n1;
    start_frame(8, 8, 1'b0, 1'b0);
    run_frame(8, 8, 1'b0, 1'b0, -1, 0, "p8_d8_n1");
  endtask

  task automatic test_parity_2stop;
    start_frame(16, 7, 1'b1, 1'b1);
    run_frame(16, 7, 1'b1, 1'b1, -1, 0, "p16_d7_p_s2");
  endtask

  task automatic test_cfg_err;
    logic [PW-1:0] bad_p [3];
    logic [3:0]    bad_d [3];
    bad_p[0] = PW'(3); bad_d[0] = 4'd8;
    bad_p[1] = PW'(8); bad_d[1] = 4'd4;
    bad_p[2] = PW'(8); bad_d[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      prescale = bad_p[i]; data_len = bad_d[i]; start_det = 1'b1;
      tick;
      start_det = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_pulse%0d got cfg_err=%b busy=%b want 1 0", i, cfg_err, busy);
      end
      tick;
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_clear%0d got cfg_err=%b busy=%b want 0 0", i, cfg_err, busy);
      end
    end
    start_frame(8, 5, 1'b0, 1'b0);
    checks++;
    if (phase !== 3'd1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_legal_accept got ph=%0d cfg_err=%b want 1 0", phase, cfg_err);
    end
    run_frame(8, 5, 1'b0, 1'b0, -1, 0, "cfg_legal_frame");
  endtask

  task automatic test_abort;
    bit seen_fd;
    start_frame(8, 8, 1'b0, 1'b0);
    repeat (37) tick;
    checks++;
    if (phase !== 3'd2 || bit_cnt !== BW'(3) || edge_cnt !== PW'(5) || bit_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_pos got ph=%0d b=%0d e=%0d bd=%b want 2 3 5 0", phase, bit_cnt, edge_cnt, bit_done);
    end
    abort = 1'b1; tick; abort = 1'b0;
    check_idle("abort_idle");
    seen_fd = 0;
    repeat (5) begin tick; if (frame_done !== 1'b0 || busy !== 1'b0) seen_fd = 1; end
    checks++;
    if (seen_fd) begin
      errors++;
      $display("FAIL abort_quiet got fd/busy high after abort want low");
    end
    prescale = PW'(8); data_len = 4'd8; abort = 1'b1; start_det = 1'b1;
    tick;
    abort = 1'b0; start_det = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start got busy=%b want 0", busy);
    end
    start_frame(4, 5, 1'b0, 1'b0);
    run_frame(4, 5, 1'b0, 1'b0, -1, 0, "after_abort");
  endtask

  task automatic test_busy_ignore;
    int c;
    start_frame(4, 5, 1'b0, 1'b0);
    repeat (2) tick;
    prescale = PW'(16); data_len = 4'd8; start_det = 1'b1;
    tick;
    start_det = 1'b0;
    checks++;
    if (phase !== 3'd1 || edge_cnt !== PW'(3)) begin
      errors++;
      $display("FAIL busy_ignore got ph=%0d e=%0d want 1 3", phase, edge_cnt);
    end
    tick;
    checks++;
    if (phase !== 3'd2 || edge_cnt !== PW'(0)) begin
      errors++;
      $display("FAIL busy_keep_cfg got ph=%0d e=%0d want 2 0", phase, edge_cnt);
    end
    c = 4;
    while (frame_done !== 1'b1 && c < 40) begin tick; c++; end
    checks++;
    if (c != 28) begin
      errors++;
      $display("FAIL busy_frame_len got %0d want 28", c);
    end
    tick;
  endtask

  task automatic test_enable_hold;
    start_frame(8, 8, 1'b0, 1'b0);
    run_frame(8, 8, 1'b0, 1'b0, 30, 10, "enable_hold");
  endtask

  task automatic test_reset_mid_parity;
    bit bad;
    start_frame(4, 5, 1'b1, 1'b0);
    repeat (25) tick;
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL rst_pos got ph=%0d want 3", phase);
    end
    #2 RST = 1'b0; #1;
    check_idle("rst_async");
    tick; tick;
    RST = 1'b1;
    bad = 0;
    repeat (30) begin tick; if (frame_done !== 1'b0 || busy !== 1'b0) bad = 1; end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_no_fd got fd/busy high after reset want low");
    end
    start_frame(4, 5, 1'b0, 1'b1);
    run_frame(4, 5, 1'b0, 1'b1, -1, 0, "after_rst");
  endtask

  initial begin
    test_reset;
    test_basic_8n1;
    test_parity_2stop;
    test_cfg_err;
    test_abort;
    test_busy_ignore;
    test_enable_hold;
    test_reset_mid_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1);
  end
endmodule
